// File: rtl/qs_bank_ctrl_if.sv
// Handshake bundle between the quicksort bank controller and its load stream,
// sort engine and unload stream partners.
interface qs_bank_ctrl_if #(
    parameter int N       = 16,
    parameter int BANKS_N = 4
);
    localparam int AW = $clog2(N);
    localparam int BW = (BANKS_N > 1) ? $clog2(BANKS_N) : 1;

    logic                   ld_vld;
    logic                   ld_last;
    logic                   ld_rdy;
    logic                   ld_we;
    logic [BW-1:0]          ld_bank;
    logic [AW-1:0]          ld_addr;
    logic                   sort_start;
    logic [BW-1:0]          sort_bank;
    logic [AW-1:0]          sort_n;
    logic                   sort_done;
    logic                   ul_vld;
    logic                   ul_rdy;
    logic [BW-1:0]          ul_bank;
    logic [AW-1:0]          ul_addr;
    logic                   ul_last;
    logic                   ul_err;
    logic [3*BANKS_N-1:0]   bank_status;

    modport slave (
        input  ld_vld, ld_last, sort_done, ul_rdy,
        output ld_rdy, ld_we, ld_bank, ld_addr, sort_start, sort_bank, sort_n,
               ul_vld, ul_bank, ul_addr, ul_last, ul_err, bank_status
    );

    modport master (
        output ld_vld, ld_last, sort_done, ul_rdy,
        input  ld_rdy, ld_we, ld_bank, ld_addr, sort_start, sort_bank, sort_n,
               ul_vld, ul_bank, ul_addr, ul_last, ul_err, bank_status
    );
endinterface

// File: rtl/qs_bank_ctrl.sv
// Bank controller for the quicksort engine: tracks each bank's lifecycle and steers
// load, sort and unload traffic to the banks in round-robin order.
module qs_bank_ctrl #(
    parameter int N       = 16,
    parameter int BANKS_N = 4
) (
    input  logic          clk,
    input  logic          rst,
    qs_bank_ctrl_if.slave bus
);

    localparam int AW = $clog2(N);
    localparam int BW = (BANKS_N > 1) ? $clog2(BANKS_N) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(BANKS_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOADING   = 3'd1,
        ST_READY     = 3'd2,
        ST_SORTING   = 3'd3,
        ST_SORTED    = 3'd4,
        ST_UNLOADING = 3'd5
    } bank_st_t;

    // Wrap on the bank count so non-power-of-two bank counts never index a missing bank.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] ptr);
        logic [BW-1:0] nxt;
        if (ptr == LAST_BANK) nxt = {BW{1'b0}};
        else                  nxt = ptr + BW'(1);
        return nxt;
    endfunction

    bank_st_t               r_status [BANKS_N];
    logic [AW-1:0]          r_n      [BANKS_N];
    logic                   r_err    [BANKS_N];
    logic [BW-1:0]          r_wr_ptr, r_srt_ptr, r_rd_ptr;
    logic [AW-1:0]          r_ld_cnt, r_ul_cnt;
    logic                   r_busy, r_sort_start;

    bank_st_t               w_status_nx [BANKS_N];
    logic [AW-1:0]          w_n_nx      [BANKS_N];
    logic                   w_err_nx    [BANKS_N];
    logic [BW-1:0]          w_wr_ptr_nx, w_srt_ptr_nx, w_rd_ptr_nx;
    logic [AW-1:0]          w_ld_cnt_nx, w_ul_cnt_nx;
    logic                   w_busy_nx, w_sort_start_nx;

    logic                   w_ld_rdy, w_ld_we, w_ld_end;
    logic                   w_ul_vld, w_ul_last, w_ul_hs;
    logic                   w_sort_go, w_sort_fin;
    logic [3*BANKS_N-1:0]   w_bank_status;

    assign w_ld_rdy   = !rst && ((r_status[r_wr_ptr] == ST_IDLE) || (r_status[r_wr_ptr] == ST_LOADING));
    assign w_ld_we    = bus.ld_vld && w_ld_rdy;
    // A word landing in the last slot closes the vector even without ld_last.
    assign w_ld_end   = w_ld_we && (bus.ld_last || (r_ld_cnt == LAST_ADDR));
    assign w_ul_vld   = !rst && ((r_status[r_rd_ptr] == ST_SORTED) || (r_status[r_rd_ptr] == ST_UNLOADING));
    assign w_ul_last  = (r_ul_cnt == r_n[r_rd_ptr]);
    assign w_ul_hs    = w_ul_vld && bus.ul_rdy;
    assign w_sort_go  = !r_busy && (r_status[r_srt_ptr] == ST_READY);
    assign w_sort_fin = r_busy && bus.sort_done;

    // Next-state for all banks, pointers and counters; each port only touches a bank in its own phase.
    always_comb begin
        for (int b = 0; b < BANKS_N; b++) begin
            w_status_nx[b] = r_status[b];
            w_n_nx[b]      = r_n[b];
            w_err_nx[b]    = r_err[b];
        end
        w_wr_ptr_nx     = r_wr_ptr;
        w_srt_ptr_nx    = r_srt_ptr;
        w_rd_ptr_nx     = r_rd_ptr;
        w_ld_cnt_nx     = r_ld_cnt;
        w_ul_cnt_nx     = r_ul_cnt;
        w_busy_nx       = r_busy;
        w_sort_start_nx = 1'b0;

        if (w_ld_we) begin
            w_n_nx[r_wr_ptr]      = r_ld_cnt;
            w_status_nx[r_wr_ptr] = w_ld_end ? ST_READY : ST_LOADING;
            w_err_nx[r_wr_ptr]    = w_ld_end && !bus.ld_last;
            w_ld_cnt_nx           = w_ld_end ? {AW{1'b0}} : (r_ld_cnt + AW'(1));
            w_wr_ptr_nx           = w_ld_end ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        end else begin
            w_ld_cnt_nx = r_ld_cnt;
            w_wr_ptr_nx = r_wr_ptr;
        end

        if (w_sort_fin) begin
            w_status_nx[r_srt_ptr] = ST_SORTED;
            w_busy_nx              = 1'b0;
            w_srt_ptr_nx           = ptr_inc(r_srt_ptr);
        end else if (w_sort_go) begin
            w_status_nx[r_srt_ptr] = ST_SORTING;
            w_busy_nx              = 1'b1;
            w_sort_start_nx        = 1'b1;
        end else begin
            w_busy_nx    = r_busy;
            w_srt_ptr_nx = r_srt_ptr;
        end

        if (w_ul_hs && w_ul_last) begin
            w_status_nx[r_rd_ptr] = ST_IDLE;
            w_err_nx[r_rd_ptr]    = 1'b0;
            w_n_nx[r_rd_ptr]      = {AW{1'b0}};
            w_ul_cnt_nx           = {AW{1'b0}};
            w_rd_ptr_nx           = ptr_inc(r_rd_ptr);
        end else if (w_ul_hs) begin
            w_status_nx[r_rd_ptr] = ST_UNLOADING;
            w_ul_cnt_nx           = r_ul_cnt + AW'(1);
        end else begin
            w_ul_cnt_nx = r_ul_cnt;
            w_rd_ptr_nx = r_rd_ptr;
        end
    end

    // State register; reset discards every in-flight vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKS_N; b++) begin
                r_status[b] <= ST_IDLE;
                r_n[b]      <= {AW{1'b0}};
                r_err[b]    <= 1'b0;
            end
            r_wr_ptr     <= {BW{1'b0}};
            r_srt_ptr    <= {BW{1'b0}};
            r_rd_ptr     <= {BW{1'b0}};
            r_ld_cnt     <= {AW{1'b0}};
            r_ul_cnt     <= {AW{1'b0}};
            r_busy       <= 1'b0;
            r_sort_start <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS_N; b++) begin
                r_status[b] <= w_status_nx[b];
                r_n[b]      <= w_n_nx[b];
                r_err[b]    <= w_err_nx[b];
            end
            r_wr_ptr     <= w_wr_ptr_nx;
            r_srt_ptr    <= w_srt_ptr_nx;
            r_rd_ptr     <= w_rd_ptr_nx;
            r_ld_cnt     <= w_ld_cnt_nx;
            r_ul_cnt     <= w_ul_cnt_nx;
            r_busy       <= w_busy_nx;
            r_sort_start <= w_sort_start_nx;
        end
    end

    // Debug view of every bank's status, bank 0 in the low bits.
    always_comb begin
        w_bank_status = {(3*BANKS_N){1'b0}};
        for (int b = 0; b < BANKS_N; b++) begin
            w_bank_status[3*b +: 3] = r_status[b];
        end
    end

    assign bus.ld_rdy      = w_ld_rdy;
    assign bus.ld_we       = w_ld_we;
    assign bus.ld_bank     = r_wr_ptr;
    assign bus.ld_addr     = r_ld_cnt;
    assign bus.sort_start  = r_sort_start;
    assign bus.sort_bank   = r_srt_ptr;
    assign bus.sort_n      = r_n[r_srt_ptr];
    assign bus.ul_vld      = w_ul_vld;
    assign bus.ul_bank     = r_rd_ptr;
    assign bus.ul_addr     = r_ul_cnt;
    assign bus.ul_last     = w_ul_last;
    assign bus.ul_err      = r_err[r_rd_ptr];
    assign bus.bank_status = w_bank_status;

endmodule

// File: doc/qs_bank_ctrl.md
Name: qs_bank_ctrl

Overview:
- Parametrised bank controller for the quicksort engine.
- Owns per-bank state for BANKS_N sort banks of N words each and advances every bank through IDLE -> LOADING -> READY -> SORTING -> SORTED -> UNLOADING -> IDLE.
- Sits between the input stream, the sort engine and the output stream, generating bank id and address for each.
- Successor to the fixed 4-bank scheme: arbitrary BANKS_N (including non-power-of-two) with correct wrap, overflow/error tracking, and concurrent load/sort/unload on distinct banks.

Parameters:
- N, 16, words per bank (>=2).
- BANKS_N, 4, number of banks (>=1, any integer).
- Derived: AW = $clog2(N); BW = max(1, $clog2(BANKS_N)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset asynchronous and active-high.
- ld_vld  in  1  input word valid.
- ld_last  in  1  final word of current vector.
- ld_rdy  out  1  controller accepts word.
- ld_we  out  1  bank write strobe (ld_vld & ld_rdy).
- ld_bank  out  BW  bank being written.
- ld_addr  out  AW  write address.
- sort_start  out  1  one-cycle pulse launching sort.
- sort_bank  out  BW  bank to sort (held until sort_done).
- sort_n  out  AW  last valid index of sort_bank.
- sort_done  in  1  sort engine completion pulse.
- ul_vld  out  1  output word valid.
- ul_rdy  in  1  downstream accepts.
- ul_bank  out  BW  bank being read.
- ul_addr  out  AW  read address.
- ul_last  out  1  final word of vector.
- ul_err  out  1  vector was truncated on load.
- bank_status  out  3*BANKS_N  packed per-bank status (bank 0 in LSBs), debug.

Behaviour:
- State: per bank {err, n[AW-1:0], status[2:0]}. Pointers wr_ptr, srt_ptr, rd_ptr; address counters ld_cnt, ul_cnt; sorter-busy flag.
- Status encoding: IDLE=0, LOADING=1, READY=2, SORTING=3, SORTED=4, UNLOADING=5.
- Reset (async, rst high): all banks IDLE, err=0, n=0; pointers, counters and busy cleared. sort_start=0. ld_rdy=0 and ul_vld=0 while rst is high.
- Pointer increment: wraps BANKS_N-1 -> 0, with comparison against BANKS_N (not N). With BANKS_N=3, 2 -> 0.
- Load:
  - ld_rdy = status[wr_ptr] in {IDLE, LOADING}. ld_bank = wr_ptr; ld_addr = ld_cnt.
  - Accept on IDLE: bank goes LOADING.
  - Each accept: n <= ld_cnt, ld_cnt++.
  - Accept with ld_last: bank goes READY, ld_cnt <= 0, wr_ptr++.
  - Accept at ld_cnt==N-1 without ld_last: treated as last, bank err <= 1, bank READY. The next word starts the next bank.
- Sort:
  - When !busy and status[srt_ptr]==READY, the next edge sets sort_start=1 for exactly one cycle, status becomes SORTING and busy is set.
  - sort_bank = srt_ptr; sort_n = n[srt_ptr].
  - sort_done while busy: bank goes SORTED, busy clears, srt_ptr++.
  - sort_done while !busy is ignored.
  - sort_done in the same cycle as a new READY bank: the new sort_start fires no earlier than the following cycle.
- Unload:
  - ul_vld = status[rd_ptr] in {SORTED, UNLOADING}. ul_bank = rd_ptr; ul_addr = ul_cnt; ul_last = (ul_cnt == n[rd_ptr]); ul_err = err[rd_ptr].
  - First handshake moves SORTED to UNLOADING.
  - Each handshake: ul_cnt++.
  - Handshake with ul_last: bank goes IDLE, err and n cleared, ul_cnt <= 0, rd_ptr++.
  - ul_vld may be asserted without waiting for ul_rdy. Outputs stay stable while ul_vld & !ul_rdy.
- Latency:
  - Last load word accepted at edge t: READY at t+1, sort_start high in cycle t+2.
  - sort_done at edge t: ul_vld high in cycle t+1.
  - Empty-to-first-output minimum is 3 cycles plus sort time.
- Concurrency:
  - Load, sort and unload transitions on different banks may all occur in one cycle; each bank has at most one writer per cycle by construction.
  - BANKS_N=1 is legal: fully serialised.
- Full: all banks non-IDLE, so ld_rdy=0 until an unload completes. The bank freed at edge t is loadable in cycle t+1 only if wr_ptr points to it.
- Reset mid-operation: all in-flight vectors are discarded and no pulses are emitted after rst deasserts. Any sort_done arriving after reset is ignored.

Test Plan:
- Single vector: 5 words, last on word 4 -> ld_addr 0..4 on bank 0; sort_start in cycle t+2 with sort_n=4; sort_done -> ul_addr 0..4, ul_last on 4, ul_err=0, bank 0 returns to IDLE.
- Overflow, N=16: 17 words, no ld_last -> bank 0 err=1 with n=15; word 17 is written to bank 1 addr 0; unload of bank 0 shows ul_err=1 and ul_last at addr 15.
- Wrap, BANKS_N=3: 4 one-word vectors -> banks 0,1,2,0 in order; fourth ld_rdy stalls until bank 0 unload completes.
- Full plus backpressure: 4 banks loaded with ul_rdy=0 -> ld_rdy=0; ul_vld held with ul_addr stable; releasing ul_rdy drains banks 0,1,2,3 in order.
- Concurrency: bank0 unloading, bank1 sort_done, bank2 last word, all in the same cycle -> all three transitions are applied; a spurious sort_done while idle causes no state change.
- Async reset asserted mid-sort -> bank_status=0 immediately, sort_start=0; a sort_done after reset is ignored.
